// File: rtl/circular_fifo_pkg.sv
// Shared FIFO-harness definitions: default geometry and occupancy counter sizing.
// Imported by the FIFO, its scoreboard and the occupancy tracker.
package circular_fifo_pkg;

    localparam int unsigned FifoDepthDefault = 8;
    localparam int unsigned FifoWidthDefault = 8;

    // Counter must hold 0..depth inclusive, hence one bit more than the pointer.
    function automatic int unsigned cnt_width(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/circular_fifo_ff.sv
// Generic enabled flop with synchronous active-high reset to zero.
// Reset wins over enable.
module circular_fifo_ff #(
    parameter int unsigned Width = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [Width-1:0] d,
    output logic [Width-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/circular_fifo.sv
// Single-clock circular FIFO with show-ahead output and qualified push/pop strobes.
// Occupancy is tracked in a counter; full/empty are decoded from it.
module circular_fifo
    import circular_fifo_pkg::*;
#(
    parameter int unsigned DEPTH  = FifoDepthDefault,
    parameter int unsigned WIDTH  = FifoWidthDefault,
    parameter int unsigned CNTWID = cnt_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [WIDTH-1:0]  data_in,
    output logic [WIDTH-1:0]  data_out,
    output logic              full,
    output logic              empty,
    output logic              push_acc,
    output logic              pop_acc,
    output logic [CNTWID-1:0] cnt
);

    localparam int unsigned PtrW = $clog2(DEPTH);

    logic [PtrW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNTWID-1:0] cnt_q, cnt_d;
    logic              cnt_en;
    logic [WIDTH-1:0]  mem_q [DEPTH];

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CNTWID'(DEPTH));
    assign cnt   = cnt_q;

    // A push into a full FIFO is only legal when a pop frees the slot this cycle.
    assign pop_acc  = pop & ~empty;
    assign push_acc = push & (~full | pop_acc);

    always_comb begin
        wr_ptr_d = wr_ptr_q + PtrW'(1);
        rd_ptr_d = rd_ptr_q + PtrW'(1);
        cnt_en   = push_acc ^ pop_acc;
        cnt_d    = push_acc ? (cnt_q + CNTWID'(1)) : (cnt_q - CNTWID'(1));
    end

    circular_fifo_ff #(.Width(PtrW)) u_wr_ptr (
        .clk (clk),
        .rst (rst),
        .en  (push_acc),
        .d   (wr_ptr_d),
        .q   (wr_ptr_q)
    );

    circular_fifo_ff #(.Width(PtrW)) u_rd_ptr (
        .clk (clk),
        .rst (rst),
        .en  (pop_acc),
        .d   (rd_ptr_d),
        .q   (rd_ptr_q)
    );

    circular_fifo_ff #(.Width(CNTWID)) u_cnt (
        .clk (clk),
        .rst (rst),
        .en  (cnt_en),
        .d   (cnt_d),
        .q   (cnt_q)
    );

    // Storage is deliberately not reset; the counter alone defines validity.
    always_ff @(posedge clk) begin
        if (push_acc && !rst) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    assign data_out = mem_q[rd_ptr_q];

endmodule

// File: tb/tb_circular_fifo.sv
// Self-checking bench for circular_fifo: directed vector table, hand sequences,
// and randomized traffic against a queue-based reference model.
module tb_circular_fifo;

    localparam int unsigned Depth = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       push = 1'b0;
    logic       pop = 1'b0;
    logic [7:0] data_in = '0;
    logic [7:0] data_out;
    logic       full, empty, push_acc, pop_acc;
    logic [3:0] cnt;

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0] mq [$];
    bit         known = 1'b0;
    int         max_cnt = 0;

    typedef struct {
        logic       rst, push, pop;
        logic [7:0] din;
        logic       chk_acc, e_pacc, e_qacc;
        logic [7:0] e_dout;
        logic [3:0] e_cnt;
    } vec_t;

    vec_t vecs [$];

    circular_fifo u_dut (
        .clk      (clk),
        .rst      (rst),
        .push     (push),
        .pop      (pop),
        .data_in  (data_in),
        .data_out (data_out),
        .full     (full),
        .empty    (empty),
        .push_acc (push_acc),
        .pop_acc  (pop_acc),
        .cnt      (cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic void add(input logic r, input logic p, input logic q, input logic [7:0] d,
                                input logic ca, input logic ep, input logic eq,
                                input logic [7:0] ed, input logic [3:0] ec);
        vec_t v;
        v.rst = r; v.push = p; v.pop = q; v.din = d;
        v.chk_acc = ca; v.e_pacc = ep; v.e_qacc = eq; v.e_dout = ed; v.e_cnt = ec;
        vecs.push_back(v);
    endfunction

    // One clock of stimulus, checked against the queue model before the edge.
    task automatic cycle(input logic r, input logic p, input logic q, input logic [7:0] d);
        bit exp_q, exp_p;
        @(negedge clk);
        rst = r; push = p; pop = q; data_in = d;
        #1;
        exp_q = q && (mq.size() != 0);
        exp_p = p && ((mq.size() < Depth) || exp_q);
        if (known) begin
            check("pop_acc", 32'(pop_acc), 32'(exp_q));
            check("push_acc", 32'(push_acc), 32'(exp_p));
            check("cnt", 32'(cnt), 32'(mq.size()));
            check("empty", 32'(empty), 32'(mq.size() == 0));
            check("full", 32'(full), 32'(mq.size() == Depth));
            if (exp_q) check("data_out", 32'(data_out), 32'(mq[0]));
            if (int'(cnt) > max_cnt) max_cnt = int'(cnt);
        end
        @(posedge clk);
        if (r) begin
            mq.delete();
            known = 1'b1;
        end else begin
            if (exp_q) void'(mq.pop_front());
            if (exp_p) mq.push_back(d);
        end
    endtask

    initial begin
        // Basic ordering: three pushes, three pops, then a rejected pop.
        add(1, 1, 0, 8'h77, 0, 0, 0, 8'h00, 0);
        add(0, 1, 0, 8'h11, 1, 1, 0, 8'h00, 1);
        add(0, 1, 0, 8'h22, 1, 1, 0, 8'h00, 2);
        add(0, 1, 0, 8'h33, 1, 1, 0, 8'h00, 3);
        add(0, 0, 1, 8'h00, 1, 0, 1, 8'h11, 2);
        add(0, 0, 1, 8'h00, 1, 0, 1, 8'h22, 1);
        add(0, 0, 1, 8'h00, 1, 0, 1, 8'h33, 0);
        add(0, 0, 1, 8'h00, 1, 0, 0, 8'h00, 0);
        // Push+pop while empty: no bypass.
        add(0, 1, 1, 8'h5C, 1, 1, 0, 8'h00, 1);
        add(0, 0, 1, 8'h00, 1, 0, 1, 8'h5C, 0);
        // Fill, overflow attempt, push+pop at full, drain.
        for (int i = 0; i < 8; i++) add(0, 1, 0, 8'(i), 1, 1, 0, 8'h00, 4'(i + 1));
        add(0, 1, 0, 8'hFF, 1, 0, 0, 8'h00, 8);
        add(0, 1, 1, 8'hAA, 1, 1, 1, 8'h00, 8);
        for (int i = 1; i < 8; i++) add(0, 0, 1, 8'h00, 1, 0, 1, 8'(i), 4'(8 - i));
        add(0, 0, 1, 8'h00, 1, 0, 1, 8'hAA, 0);

        foreach (vecs[i]) begin
            @(negedge clk);
            rst = vecs[i].rst; push = vecs[i].push; pop = vecs[i].pop; data_in = vecs[i].din;
            #1;
            if (vecs[i].chk_acc) begin
                check($sformatf("vec%0d push_acc", i), 32'(push_acc), 32'(vecs[i].e_pacc));
                check($sformatf("vec%0d pop_acc", i), 32'(pop_acc), 32'(vecs[i].e_qacc));
                if (vecs[i].e_qacc)
                    check($sformatf("vec%0d data_out", i), 32'(data_out), 32'(vecs[i].e_dout));
            end
            @(posedge clk);
            #1;
            check($sformatf("vec%0d cnt", i), 32'(cnt), 32'(vecs[i].e_cnt));
            check($sformatf("vec%0d empty", i), 32'(empty), 32'(vecs[i].e_cnt == 0));
            check($sformatf("vec%0d full", i), 32'(full), 32'(vecs[i].e_cnt == 4'd8));
        end
        known = 1'b1;

        // Reset mid-operation with a concurrent push discards everything.
        cycle(1, 0, 0, 8'h00);
        for (int i = 0; i < 5; i++) cycle(0, 1, 0, 8'($urandom));
        cycle(1, 1, 0, 8'h99);
        cycle(0, 1, 0, 8'h3E);
        cycle(0, 0, 1, 8'h00);
        cycle(0, 0, 0, 8'h00);

        // Alternating push/pop pairs walk the pointers around twice.
        cycle(1, 0, 0, 8'h00);
        max_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(0, 1, 0, 8'($urandom));
            cycle(0, 0, 1, 8'h00);
        end
        cycle(0, 0, 0, 8'h00);
        check("wrap_max_cnt", 32'(max_cnt), 32'd1);

        // Random traffic: fill-biased phase then drain-biased phase, rare resets.
        for (int i = 0; i < 800; i++) begin
            logic r, p, q;
            int   pb;
            pb = (i < 400) ? 70 : 30;
            r = ($urandom_range(0, 99) == 0);
            p = ($urandom_range(0, 99) < pb);
            q = ($urandom_range(0, 99) < (100 - pb));
            cycle(r, p, q, 8'($urandom));
        end
        cycle(0, 0, 0, 8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
